// File: rtl/data_bus_ctrl.sv
// MEM-stage load/store bus controller: turns one lane-aligned pipeline access into a
// request/grant/response bus transaction, stalling the pipeline until it completes.
module data_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_misaligned_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic        lsu_err_o,
  output logic [31:0] lsu_rdata_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;

  // The counter is meaningful only in REQ/WAIT; a zero TIMEOUT_CYCLES never fires.
  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (lsu_req_i) w_state_next = lsu_misaligned_i ? S_RESP : S_REQ;
      S_REQ: begin
        if (data_gnt_i)     w_state_next = S_WAIT;
        else if (w_timeout) w_state_next = S_RESP;
      end
      S_WAIT: if (data_rvalid_i || w_timeout) w_state_next = S_RESP;
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    data_req_o   = (r_state == S_REQ);
    lsu_done_o   = (r_state == S_RESP);
    lsu_err_o    = (r_state == S_RESP) && r_err;
    lsu_stall_o  = ((r_state == S_IDLE) && lsu_req_i) || (r_state == S_REQ) || (r_state == S_WAIT);
    lsu_rdata_o  = r_rdata;
    data_addr_o  = r_addr;
    data_we_o    = r_we;
    data_be_o    = r_be;
    data_wdata_o = r_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (lsu_req_i) begin
            r_err <= lsu_misaligned_i;
            if (!lsu_misaligned_i) begin
              r_we    <= lsu_we_i;
              r_addr  <= {lsu_addr_i[31:2], 2'b00};
              r_be    <= lsu_be_i;
              r_wdata <= lsu_wdata_i;
            end
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (w_timeout) r_err <= 1'b1;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          // A response in the last allowed cycle still wins over the timeout.
          if (data_rvalid_i) begin
            r_err <= data_err_i;
            if (!r_we && !data_err_i) r_rdata <= data_rdata_i;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Scoreboard bench for data_bus_ctrl: a driver plays pipeline and bus, pushing the
// per-access outcome predicted from bus delays; a monitor checks every bus cycle and completion.
module tb_data_bus_ctrl;

  logic        clk_i = 0;
  logic        rst_ni = 0;
  logic        lsu_req_i = 0, lsu_we_i = 0, lsu_misaligned_i = 0;
  logic [31:0] lsu_addr_i = 0, lsu_wdata_i = 0;
  logic [3:0]  lsu_be_i = 0;
  logic        lsu_stall_o, lsu_done_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_we_o;
  logic        data_gnt_i = 0, data_rvalid_i = 0, data_err_i = 0;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = 0;
  logic [3:0]  data_be_o;

  data_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_be_i(lsu_be_i), .lsu_wdata_i(lsu_wdata_i), .lsu_misaligned_i(lsu_misaligned_i),
    .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o),
    .lsu_rdata_o(lsu_rdata_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          reqc;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  int          req_cnt = 0, stall_cnt = 0;
  logic [31:0] model_rdata = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: bus-side checks while requesting, outcome checks at completion.
  always @(negedge clk_i) begin
    exp_t e;
    if (mon_en) begin
      if (lsu_stall_o) stall_cnt++;
      if (data_req_o) begin
        if (sb.size() == 0) chk("req_without_access", 1, 0);
        else begin
          e = sb[0];
          chk("bus_addr", data_addr_o, {e.addr[31:2], 2'b00});
          chk("bus_we", data_we_o, e.we);
          chk("bus_be", data_be_o, e.be);
          chk("bus_wdata", data_wdata_o, e.wdata);
          req_cnt++;
        end
      end
      if (lsu_err_o && !lsu_done_o) chk("err_without_done", 1, 0);
      if (lsu_done_o) begin
        if (sb.size() == 0) chk("done_without_access", 1, 0);
        else begin
          e = sb.pop_front();
          chk("err", lsu_err_o, e.err);
          chk("rdata", lsu_rdata_o, e.rdata);
          chk("latency", cyc - e.acc, e.lat);
          chk("req_cycles", req_cnt, e.reqc);
          chk("stall_cycles", stall_cnt, e.lat);
          $display("txn acc=%0d we=%0d addr=%08h err=%0d rdata=%08h lat=%0d",
                   e.acc, e.we, e.addr, lsu_err_o, lsu_rdata_o, cyc - e.acc);
        end
        req_cnt = 0;
        stall_cnt = 0;
      end
    end
  end

  task automatic rand_bus();
    data_gnt_i    = 1'($urandom_range(0, 1));
    data_rvalid_i = 1'($urandom_range(0, 1));
    data_err_i    = 1'($urandom_range(0, 1));
    data_rdata_i  = $urandom;
  endtask

  // d = grant wait cycles, r = rvalid wait cycles after grant; 4 or more means timeout.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic mis, input int d, input int r,
                        input logic [31:0] rdat, input logic derr, input int gap);
    exp_t e;
    logic to;
    repeat (gap) begin
      @(posedge clk_i); #1;
      lsu_req_i = 0;
      rand_bus();
    end
    @(posedge clk_i); #1;
    lsu_req_i = 1; lsu_we_i = we; lsu_addr_i = addr; lsu_be_i = be;
    lsu_wdata_i = wdata; lsu_misaligned_i = mis;
    rand_bus();
    e.addr = addr; e.we = we; e.be = be; e.wdata = wdata; e.acc = cyc;
    if (mis) begin
      e.err = 1; e.lat = 1; e.reqc = 0;
    end else if (d >= 4) begin
      e.err = 1; e.lat = 5; e.reqc = 4;
    end else if (r >= 4) begin
      e.err = 1; e.lat = d + 6; e.reqc = d + 1;
    end else begin
      e.err = derr; e.lat = d + r + 3; e.reqc = d + 1;
      if (!we && !derr) model_rdata = rdat;
    end
    e.rdata = model_rdata;
    sb.push_back(e);
    if (!mis) begin
      to = 0;
      for (int k = 0; k < 64; k++) begin
        @(posedge clk_i); #1;
        data_gnt_i    = (k == d);
        data_rvalid_i = (k == d) && ($urandom_range(0, 1) == 1);
        data_err_i    = 1'($urandom_range(0, 1));
        data_rdata_i  = $urandom;
        if (k == d) break;
        if (k == 3) begin to = 1; break; end
      end
      if (!to) begin
        for (int k = 0; k < 64; k++) begin
          @(posedge clk_i); #1;
          data_gnt_i    = 0;
          data_rvalid_i = (k == r);
          data_err_i    = (k == r) ? derr : 1'($urandom_range(0, 1));
          data_rdata_i  = (k == r) ? rdat : $urandom;
          if (k == r || k == 3) break;
        end
      end
    end
    @(posedge clk_i); #1;
    rand_bus();
    if (!mis && d >= 4) data_gnt_i = 1;
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached with %0d accesses pending", sb.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic mis, we, derr;
    int d, r;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs", {lsu_stall_o, lsu_done_o, lsu_err_o, lsu_rdata_o, data_req_o,
                          data_addr_o, data_we_o, data_be_o, data_wdata_o}, 0);
    rst_ni = 1;

    // Async reset in WAIT: everything clears at once, a late rvalid is discarded.
    @(posedge clk_i); #1;
    lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h3000; lsu_be_i = 4'hF;
    @(posedge clk_i); #1;
    data_gnt_i = 1;
    @(posedge clk_i); #1;
    data_gnt_i = 0;
    chk("wait_stall", lsu_stall_o, 1);
    #2;
    rst_ni = 0; lsu_req_i = 0;
    #1;
    chk("async_reset_outputs", {lsu_stall_o, lsu_done_o, lsu_err_o, lsu_rdata_o, data_req_o,
                                data_addr_o, data_we_o, data_be_o, data_wdata_o}, 0);
    @(posedge clk_i); #1;
    rst_ni = 1; data_rvalid_i = 1; data_rdata_i = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("no_done_after_reset", {lsu_done_o, data_req_o, lsu_rdata_o}, 0);
      data_rvalid_i = 0;
    end
    mon_en = 1;

    do_txn(0, 32'h0000_1004, 4'hF, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    do_txn(1, 32'h0000_2003, 4'h8, 32'hAB00_0000, 0, 2, 0, 32'h1111_2222, 0, 1);
    do_txn(0, 32'h0000_1001, 4'hF, 32'h0, 1, 0, 0, 32'h0, 0, 0);
    do_txn(0, 32'h0000_0040, 4'hF, 32'h0, 0, 1, 1, 32'h3333_4444, 1, 0);
    do_txn(0, 32'h0000_0080, 4'hF, 32'h0, 0, 10, 0, 32'h6666_7777, 0, 0);
    do_txn(0, 32'h0000_00C0, 4'hF, 32'h0, 0, 0, 7, 32'h8888_9999, 0, 2);

    for (int n = 0; n < 150; n++) begin
      mis  = ($urandom_range(0, 7) == 0);
      we   = 1'($urandom_range(0, 1));
      derr = ($urandom_range(0, 7) == 0);
      d    = ($urandom_range(0, 7) == 0) ? 4 + $urandom_range(0, 2) : $urandom_range(0, 3);
      r    = ($urandom_range(0, 7) == 0) ? 4 + $urandom_range(0, 2) : $urandom_range(0, 3);
      do_txn(we, $urandom, 4'($urandom), $urandom, mis, d, r, $urandom, derr,
             $urandom_range(0, 2));
    end

    @(posedge clk_i); #1;
    lsu_req_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
    repeat (10) @(posedge clk_i);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_bus_ctrl.md
# data_bus_ctrl

Load/store bus controller for the MEM stage, sitting directly downstream of the byte-lane alignment logic. It takes the pipeline's byte-enabled, lane-aligned access and runs a request/grant/response transaction on the data memory bus. It stalls the pipeline for the duration of the access and returns the raw 32-bit read word to the alignment logic for extraction and sign extension. Misaligned accesses, bus errors and bus timeouts are reported as a single one-cycle error pulse.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 16: maximum cycles spent in REQ or in WAIT before the access is abandoned. A value of 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- lsu_req_i  in  1  pipeline load/store request; held stable until the cycle lsu_done_o is high.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_addr_i  in  32  byte address.
- lsu_be_i  in  4  byte enables, already lane-aligned.
- lsu_wdata_i  in  32  store data, already lane-aligned.
- lsu_misaligned_i  in  1  misalignment flag from the alignment logic.
- lsu_stall_o  out  1  pipeline stall.
- lsu_done_o  out  1  one-cycle completion pulse.
- lsu_err_o  out  1  one-cycle error pulse, coincident with lsu_done_o.
- lsu_rdata_o  out  32  raw read word, not aligned.
- data_req_o  out  1  bus request.
- data_gnt_i  in  1  bus grant.
- data_addr_o  out  32  word address, {addr[31:2], 2'b00}.
- data_we_o  out  1  bus write enable.
- data_be_o  out  4  bus byte enables.
- data_wdata_o  out  32  bus write data.
- data_rvalid_i  in  1  response valid; asserted for both loads and stores.
- data_rdata_i  in  32  response data.
- data_err_i  in  1  response error, sampled only when data_rvalid_i is high.

## Operation

- FSM states: IDLE, REQ, WAIT, RESP. All registers and outputs reset to 0; the state resets to IDLE.
- IDLE:
  - On lsu_req_i with lsu_misaligned_i = 0: latch we, addr, be and wdata, then go to REQ.
  - On lsu_req_i with lsu_misaligned_i = 1: set the error flag and go to RESP. No bus activity occurs.
  - data_rvalid_i and data_gnt_i are ignored in IDLE.
- REQ:
  - data_req_o = 1, and the data_* outputs drive the latched values. These stay constant until grant.
  - On data_gnt_i: go to WAIT and deassert data_req_o the next cycle.
- WAIT:
  - On data_rvalid_i: go to RESP, set the error flag = data_err_i, and, for a load with data_err_i = 0, load lsu_rdata_o from data_rdata_i.
  - For stores and for errored loads, lsu_rdata_o keeps its previous value.
- RESP: lsu_done_o = 1, lsu_err_o = error flag. Go to IDLE unconditionally. A new request is never accepted in RESP.
- Stall: lsu_stall_o = (state==IDLE & lsu_req_i) | state==REQ | state==WAIT. lsu_stall_o is 0 in RESP, so the instruction retires that cycle.
- Timeout counter:
  - Clears on entry to REQ and on grant.
  - Increments each cycle spent in REQ or WAIT.
  - When TIMEOUT_CYCLES > 0 and the count equals TIMEOUT_CYCLES-1 without the awaited grant or rvalid, set the error flag, drop data_req_o and go to RESP.
  - A late grant or rvalid arriving after this is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1 bit.
- data_req_o, lsu_done_o and lsu_err_o are registered state decodes. lsu_stall_o is combinational.

## Timing

- Zero-wait bus (grant in the first REQ cycle, rvalid the cycle after grant):
  - Cycle 0: IDLE, request accepted.
  - Cycle 1: REQ with grant.
  - Cycle 2: WAIT with rvalid.
  - Cycle 3: RESP.
  - Total latency is 3 cycles from acceptance to lsu_done_o, with the stall high in cycles 0-2.
- Each grant wait cycle and each rvalid wait cycle adds 1 cycle.
- Misaligned access: cycle 0 IDLE (stall = 1), cycle 1 RESP with done = 1 and err = 1.
- Back-to-back requests: the earliest acceptance of the next request is the cycle after RESP, so the minimum spacing is 4 cycles.
- Simultaneous data_gnt_i and data_rvalid_i in REQ: rvalid is ignored. The bus must not return rvalid before grant.
- If rst_ni asserts mid-transaction, the FSM returns to IDLE and all outputs go to 0 immediately. The outstanding bus response is discarded.

## Test plan

- Aligned load at 0x0000_1004 with be = 4'b1111, zero-wait bus, rdata = 0xDEAD_BEEF:
  - data_addr_o = 0x0000_1004, stall high for 3 cycles.
  - Cycle 3: done = 1, err = 0, lsu_rdata_o = 0xDEAD_BEEF.
- Byte store to 0x0000_2003 with be = 4'b1000 and wdata = 0xAB00_0000, grant delayed 2 cycles:
  - data_req_o held for 3 cycles with constant addr 0x0000_2000, we = 1, be = 4'b1000.
  - done = 1 five cycles after acceptance, and lsu_rdata_o is unchanged.
- Misaligned word load:
  - data_req_o never asserts.
  - The next cycle shows done = 1 and err = 1, with stall high for exactly 1 cycle.
- Load with rvalid and data_err_i = 1:
  - err = 1 in the RESP cycle.
  - lsu_rdata_o keeps the previous value (0xDEAD_BEEF).
- TIMEOUT_CYCLES = 4, grant never asserted:
  - data_req_o is high for 4 cycles, then drops.
  - RESP follows with done = 1 and err = 1. A grant injected one cycle later produces no activity.
- Reset asserted while in WAIT:
  - All outputs are 0 and the state is IDLE asynchronously.
  - An rvalid after reset release produces no done pulse.
